skinny_sbox_serial_ctrl: RTL and testbench

- Nibble-serial scheduler for the shared 4-bit SKINNY S-box instance `sbox`.
- `sbox` is clocked, has no reset, and latency is 1 edge: SI sampled at posedge, SO valid the following cycle.
- Accepts a full state word over a valid/ready handshake and issues one nibble per cycle to the S-box.
- Collects the substituted nibbles and returns the whole substituted word over a second valid/ready handshake. Sits between the round-state register and the S-box in the serial round datapath.

---
 rtl/skinny_sbox_serial_ctrl.sv | 96 +++++++++
 tb/tb_skinny_sbox_serial_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox_serial_ctrl.sv
// Nibble-serial scheduler for a shared, clocked 4-bit SKINNY S-box.
// Issues one cell per cycle and gathers the substituted cells into a full word.
module skinny_sbox_serial_ctrl #(
  parameter int NIBBLES = 16,
  parameter int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   sbox_si,
  input  logic [3:0]   sbox_so,
  output logic         busy
);

  // Handshakes: a transfer happens on the rising clk edge where valid and
  // ready are both high; valid never depends combinationally on ready.

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       in_buf;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W-1:0]   cap_idx;
  logic               cap_v;
  logic               accept;

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (issue_idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture trails issue by one cycle to match the S-box's one-edge latency;
  // cap_v gates sbox_so so stale or unreset S-box output is never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_buf    <= '0;
      issue_idx <= '0;
      cap_idx   <= '0;
      cap_v     <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        in_buf    <= in_data;
        issue_idx <= '0;
      end else if ((state == RUN) && (issue_idx != LAST_IDX)) begin
        issue_idx <= issue_idx + 1'b1;
      end
      cap_v   <= (state == RUN);
      cap_idx <= issue_idx;
      if (cap_v) begin
        out_data[{cap_idx, 2'b00} +: 4] <= sbox_so;
      end
    end
  end

  always_comb begin
    sbox_si = 4'h0;
    if (state == RUN) begin
      sbox_si = in_buf[{issue_idx, 2'b00} +: 4];
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_skinny_sbox_serial_ctrl.sv
// Self-checking bench for skinny_sbox_serial_ctrl: a 16-cell instance and a
// 4-cell instance, each wired to a behavioural clocked S-box.
module tb_skinny_sbox_serial_ctrl;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]  in_data, out_data;
  logic [3:0]   sbox_si, sbox_so;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [15:0]  s_in_data, s_out_data;
  logic [3:0]   s_sbox_si, s_sbox_so;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  in_q[$];
  logic [63:0]  ref_q[$];
  logic [63:0]  last_out;

  skinny_sbox_serial_ctrl #(.NIBBLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sbox_si(sbox_si), .sbox_so(sbox_so), .busy(busy)
  );

  skinny_sbox_serial_ctrl #(.NIBBLES(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .sbox_si(s_sbox_si), .sbox_so(s_sbox_so), .busy(s_busy)
  );

  // ---------------- clock / reset / S-box models ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sbox_fn(input logic [3:0] x);
    case (x)
      4'h0: sbox_fn = 4'hC;  4'h1: sbox_fn = 4'h6;  4'h2: sbox_fn = 4'h9;  4'h3: sbox_fn = 4'h0;
      4'h4: sbox_fn = 4'h1;  4'h5: sbox_fn = 4'hA;  4'h6: sbox_fn = 4'h2;  4'h7: sbox_fn = 4'hB;
      4'h8: sbox_fn = 4'h3;  4'h9: sbox_fn = 4'h8;  4'hA: sbox_fn = 4'h5;  4'hB: sbox_fn = 4'hD;
      4'hC: sbox_fn = 4'h4;  4'hD: sbox_fn = 4'hE;  4'hE: sbox_fn = 4'h7;  default: sbox_fn = 4'hF;
    endcase
  endfunction

  // S-box instances: clocked, unreset, one edge of latency
  always @(posedge clk) sbox_so   <= sbox_fn(sbox_si);
  always @(posedge clk) s_sbox_so <= sbox_fn(s_sbox_si);

  function automatic logic [63:0] word_ref(input logic [63:0] d, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[4*k +: 4] = sbox_fn(d[4*k +: 4]);
    return r;
  endfunction

  // ---------------- driver + per-cycle reference model ----------------
  // Consumes in_q/ref_q. The model tracks only "accepted at edge A" and
  // derives every expected output from the edge count since acceptance.
  task automatic run_stream(input int stall, input bit rnd);
    bit          active;
    int          acc_cyc, k, budget, limit;
    logic [63:0] cur;
    bit          exp_ir, exp_busy, exp_ov;
    logic [3:0]  exp_si;
    active = 0; acc_cyc = 0; budget = 0; cur = '0;
    limit  = (in_q.size() + 1) * (N + 8 + stall) * (rnd ? 6 : 1) + 20;
    while ((in_q.size() > 0 || active) && budget < limit) begin
      @(negedge clk);
      budget++;
      k = active ? (cyc - acc_cyc) : 0;
      exp_ir   = !active;
      exp_busy = active && (k <= N);
      exp_ov   = active && (k >= N + 1);
      exp_si   = (active && k < N) ? cur[4*k +: 4] : 4'h0;
      checks++;
      if (in_ready !== exp_ir) begin
        errors++; $display("FAIL in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ir);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL busy cyc %0d: got %b expected %b", cyc, busy, exp_busy);
      end
      checks++;
      if (out_valid !== exp_ov) begin
        errors++; $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_ov);
      end
      checks++;
      if (sbox_si !== exp_si) begin
        errors++; $display("FAIL sbox_si cyc %0d: got %h expected %h", cyc, sbox_si, exp_si);
      end
      if (exp_ov && exp_q.size() > 0) begin
        checks++;
        if (out_data !== exp_q[0]) begin
          errors++; $display("FAIL out_data cyc %0d: got %h expected %h", cyc, out_data, exp_q[0]);
        end
      end else if (!active) begin
        checks++;
        if (out_data !== last_out) begin
          errors++; $display("FAIL out_data_hold cyc %0d: got %h expected %h", cyc, out_data, last_out);
        end
      end
      // drive next-edge inputs
      if (in_q.size() > 0) begin
        in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = in_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
      end
      if (rnd) out_ready = $urandom_range(0, 1) != 0;
      else     out_ready = exp_ov ? ((k - (N + 1)) >= stall) : 1'b1;
      // model update for the coming edge
      if (exp_ov && out_ready) begin
        if (exp_q.size() > 0) last_out = exp_q.pop_front();
        active = 0;
      end else if (!active && in_valid) begin
        active  = 1;
        acc_cyc = cyc + 1;
        cur     = in_q.pop_front();
        exp_q.push_back(ref_q.pop_front());
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (active || in_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d words pending expected 0", in_q.size() + (active ? 1 : 0));
      in_q.delete(); ref_q.delete();
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic [63:0] e);
    in_q.push_back(d);
    ref_q.push_back(e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
    last_out = '0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sbox_si !== 4'h0) begin errors++; $display("FAIL reset_sbox_si: got %h expected 0", sbox_si); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_spec_vectors();
    push_word(64'hFEDCBA9876543210, 64'hF7E4D583B2A1096C);
    push_word(64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC);
    push_word(64'h3333333333333333, 64'h0000000000000000);
    run_stream(0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom};
      push_word(d, word_ref(d, N));
    end
    run_stream(5, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom};
      push_word(d, word_ref(d, N));
    end
    run_stream(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (sbox_si !== 4'h0) begin errors++; $display("FAIL mid_sbox_si: got %h expected 0", sbox_si); end
    exp_q.delete();
    last_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    push_word(64'hFEDCBA9876543210, 64'hF7E4D583B2A1096C);
    run_stream(0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      push_word(d, word_ref(d, N));
    end
    run_stream(0, 1'b1);
  endtask

  task automatic small_word(input logic [15:0] d, input logic [15:0] e);
    int edges;
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_data  = d;
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL small_in_ready: got %b expected 1", s_in_ready); end
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    s_in_data = 16'($urandom);
    edges = 0;
    while (!s_out_valid && edges < 12) begin
      @(posedge clk);
      #1 edges++;
    end
    checks++; if (edges !== 5) begin errors++; $display("FAIL small_latency: got %0d expected 5", edges); end
    checks++; if (s_out_data !== e) begin errors++; $display("FAIL small_out_data: got %h expected %h", s_out_data, e); end
    @(negedge clk);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1 s_out_ready = 1'b0;
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL small_out_valid_drop: got %b expected 0", s_out_valid); end
    checks++; if (s_out_data !== e) begin errors++; $display("FAIL small_out_data_hold: got %h expected %h", s_out_data, e); end
  endtask

  task automatic test_small_config();
    logic [63:0] r;
    logic [15:0] d;
    small_word(16'h0123, 16'hC690);
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      r = word_ref({48'h0, d}, 4);
      small_word(d, r[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_small_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
